// File: rtl/video_timing_controller_pkg.sv
// Shared types and helpers for the raster timing generator.
package video_timing_controller_pkg;

  localparam int CW = 14;

  typedef logic [CW-1:0] coord_t;

  // Per-axis decode of the raw counter.
  typedef struct packed {
    coord_t pos;
    logic   sync;
    logic   act;
  } axis_t;

  function automatic logic pol_level(input logic asserted, input logic pol);
    return pol ? asserted : ~asserted;
  endfunction

endpackage

// File: rtl/video_timing_controller_axis_counter.sv
// One raster axis: wrapping counter with carry-in enable, restart load and sync/active window decode.
// The decode is combinational from the current count; the top registers it.
module video_axis_counter
  import video_timing_controller_pkg::*;
#(
  parameter int length   = 2200,
  parameter int sync_len = 44,
  parameter int start    = 192,
  parameter int visible  = 1920
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  restart,
  input  logic  en,
  output axis_t st
);

  coord_t cnt;
  logic   last;

  assign last = (cnt == coord_t'(length - 1));

  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + coord_t'(1);
    end
  end

  always_comb begin
    st      = '0;
    st.pos  = cnt;
    st.sync = (cnt < coord_t'(sync_len));
    st.act  = (cnt >= coord_t'(start)) && (cnt < coord_t'(start + visible));
  end

endmodule

// File: rtl/video_timing_controller.sv
// Free-running progressive raster generator: sync, data enable, line-start strobe and active coordinates.
// Every output is registered one clock after the counter state it decodes; ext_sync restarts the frame.
module video_timing_controller
  import video_timing_controller_pkg::*;
#(
  parameter int video_hlength   = 2200,
  parameter int video_vlength   = 1125,
  parameter int video_hsync_pol = 1,
  parameter int video_hsync_len = 44,
  parameter int video_hbp_len   = 148,
  parameter int video_h_visible = 1920,
  parameter int video_vsync_pol = 1,
  parameter int video_vsync_len = 5,
  parameter int video_vbp_len   = 36,
  parameter int video_v_visible = 1080
) (
  input  logic          pixel_clock,
  input  logic          reset,
  input  logic          ext_sync,
  output logic [CW-1:0] timing_h_pos,
  output logic [CW-1:0] timing_v_pos,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          video_vsync,
  output logic          video_hsync,
  output logic          video_den,
  output logic          video_line_start
);

  localparam int   HS   = video_hsync_len + video_hbp_len;
  localparam int   VS   = video_vsync_len + video_vbp_len;
  localparam logic HPOL = (video_hsync_pol != 0);
  localparam logic VPOL = (video_vsync_pol != 0);

  axis_t h_st;
  axis_t v_st;
  logic  h_last;
  logic  den;

  assign h_last = (h_st.pos == coord_t'(video_hlength - 1));
  assign den    = h_st.act & v_st.act;

  video_axis_counter #(
    .length  (video_hlength),
    .sync_len(video_hsync_len),
    .start   (HS),
    .visible (video_h_visible)
  ) u_h_axis (
    .clk    (pixel_clock),
    .reset  (reset),
    .restart(ext_sync),
    .en     (1'b1),
    .st     (h_st)
  );

  // Vertical axis advances only on the last clock of each line.
  video_axis_counter #(
    .length  (video_vlength),
    .sync_len(video_vsync_len),
    .start   (VS),
    .visible (video_v_visible)
  ) u_v_axis (
    .clk    (pixel_clock),
    .reset  (reset),
    .restart(ext_sync),
    .en     (h_last),
    .st     (v_st)
  );

  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      timing_h_pos     <= '0;
      timing_v_pos     <= '0;
      pixel_x          <= '0;
      pixel_y          <= '0;
      video_hsync      <= ~HPOL;
      video_vsync      <= ~VPOL;
      video_den        <= 1'b0;
      video_line_start <= 1'b0;
    end else begin
      timing_h_pos     <= h_st.pos;
      timing_v_pos     <= v_st.pos;
      pixel_x          <= den ? h_st.pos - coord_t'(HS) : '0;
      pixel_y          <= den ? v_st.pos - coord_t'(VS) : '0;
      video_hsync      <= pol_level(h_st.sync, HPOL);
      video_vsync      <= pol_level(v_st.sync, VPOL);
      video_den        <= den;
      video_line_start <= den && (h_st.pos == coord_t'(HS));
    end
  end

endmodule

// File: tb/tb_video_timing_controller.sv
// Two small-raster instances (active-high and active-low sync) checked cycle by cycle against a positional model.
module tb_video_timing_controller;

  localparam int AHL = 16, AVL = 8,  AHS = 2, AHB = 2, AHV = 8,  AVS = 1, AVB = 1, AVV = 4, APOL = 1;
  localparam int BHL = 20, BVL = 10, BHS = 3, BHB = 4, BHV = 10, BVS = 2, BVB = 2, BVV = 5, BPOL = 0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ext_sync = 1'b0;

  logic [13:0] a_h, a_v, a_x, a_y, b_h, b_v, b_x, b_y;
  logic a_vs, a_hs, a_den, a_ls, b_vs, b_hs, b_den, b_ls;

  int ncmp = 0;
  int nfail = 0;
  int ah = 0, av = 0, bh = 0, bv = 0;

  always #5 clk = ~clk;

  video_timing_controller #(
    .video_hlength(AHL), .video_vlength(AVL), .video_hsync_pol(APOL), .video_hsync_len(AHS),
    .video_hbp_len(AHB), .video_h_visible(AHV), .video_vsync_pol(APOL), .video_vsync_len(AVS),
    .video_vbp_len(AVB), .video_v_visible(AVV)
  ) dut_a (
    .pixel_clock(clk), .reset(reset), .ext_sync(ext_sync),
    .timing_h_pos(a_h), .timing_v_pos(a_v), .pixel_x(a_x), .pixel_y(a_y),
    .video_vsync(a_vs), .video_hsync(a_hs), .video_den(a_den), .video_line_start(a_ls)
  );

  video_timing_controller #(
    .video_hlength(BHL), .video_vlength(BVL), .video_hsync_pol(BPOL), .video_hsync_len(BHS),
    .video_hbp_len(BHB), .video_h_visible(BHV), .video_vsync_pol(BPOL), .video_vsync_len(BVS),
    .video_vbp_len(BVB), .video_v_visible(BVV)
  ) dut_b (
    .pixel_clock(clk), .reset(reset), .ext_sync(ext_sync),
    .timing_h_pos(b_h), .timing_v_pos(b_v), .pixel_x(b_x), .pixel_y(b_y),
    .video_vsync(b_vs), .video_hsync(b_hs), .video_den(b_den), .video_line_start(b_ls)
  );

  // Expected outputs for raster position (h,v): {h,v,x,y,vsync,hsync,den,line_start}.
  function automatic logic [59:0] decode(input int h, input int v, input int hsl, input int hbp,
                                         input int hvis, input int vsl, input int vbp, input int vvis,
                                         input int pol);
    int   hs = hsl + hbp;
    int   vs = vsl + vbp;
    logic den = (h >= hs) && (h < hs + hvis) && (v >= vs) && (v < vs + vvis);
    logic hsy = ((h < hsl) == (pol != 0));
    logic vsy = ((v < vsl) == (pol != 0));
    int   x = den ? h - hs : 0;
    int   y = den ? v - vs : 0;
    return {14'(h), 14'(v), 14'(x), 14'(y), vsy, hsy, den, logic'(den && h == hs)};
  endfunction

  function automatic logic [59:0] rst_vec(input int pol);
    return {56'b0, logic'(pol == 0), logic'(pol == 0), 2'b00};
  endfunction

  task automatic adv(inout int h, inout int v, input int hl, input int vl);
    if (h == hl - 1) begin
      h = 0;
      v = (v == vl - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  task automatic check(input string tag, input logic [59:0] obs, input logic [59:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e);
    logic [59:0] ea, eb;
    reset    = r;
    ext_sync = e;
    @(posedge clk);
    #1;
    ea = r ? decode(ah, av, AHS, AHB, AHV, AVS, AVB, AVV, APOL) : rst_vec(APOL);
    eb = r ? decode(bh, bv, BHS, BHB, BHV, BVS, BVB, BVV, BPOL) : rst_vec(BPOL);
    check("inst_a", {a_h, a_v, a_x, a_y, a_vs, a_hs, a_den, a_ls}, ea);
    check("inst_b", {b_h, b_v, b_x, b_y, b_vs, b_hs, b_den, b_ls}, eb);
    if (!r || e) begin
      ah = 0; av = 0; bh = 0; bv = 0;
    end else begin
      adv(ah, av, AHL, AVL);
      adv(bh, bv, BHL, BVL);
    end
  endtask

  initial begin
    int a_den_n = 0, a_ls_n = 0, a_hs_n = 0, a_vs_n = 0;
    int b_den_n = 0, b_ls_n = 0, b_hs_n = 0, b_vs_n = 0;
    int nfa, nfb;
    bit found;

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

    // Release: first decoded state is (0,0), so sync goes active immediately.
    step(1'b1, 1'b0);
    check("release_a", 60'({a_hs, a_vs, a_h, a_v}), 60'({1'b1, 1'b1, 14'd0, 14'd0}));
    check("release_b", 60'({b_hs, b_vs, b_h, b_v}), 60'({1'b0, 1'b0, 14'd0, 14'd0}));

    // 3200 decoded clocks = exactly 25 frames of A and 16 frames of B.
    for (int i = 1; i < 3200; i++) begin
      if (i > 1 || 1) begin
        a_den_n += a_den; a_ls_n += a_ls; a_hs_n += a_hs; a_vs_n += a_vs;
        b_den_n += b_den; b_ls_n += b_ls; b_hs_n += !b_hs; b_vs_n += !b_vs;
      end
      step(1'b1, 1'b0);
    end
    a_den_n += a_den; a_ls_n += a_ls; a_hs_n += a_hs; a_vs_n += a_vs;
    b_den_n += b_den; b_ls_n += b_ls; b_hs_n += !b_hs; b_vs_n += !b_vs;
    nfa = 3200 / (AHL * AVL);
    nfb = 3200 / (BHL * BVL);
    check("a_den_count",   60'(a_den_n), 60'(nfa * AHV * AVV));
    check("a_lstart_count", 60'(a_ls_n), 60'(nfa * AVV));
    check("a_hsync_count", 60'(a_hs_n),  60'(nfa * AVL * AHS));
    check("a_vsync_count", 60'(a_vs_n),  60'(nfa * AVS * AHL));
    check("b_den_count",   60'(b_den_n), 60'(nfb * BHV * BVV));
    check("b_lstart_count", 60'(b_ls_n), 60'(nfb * BVV));
    check("b_hsync_count", 60'(b_hs_n),  60'(nfb * BVL * BHS));
    check("b_vsync_count", 60'(b_vs_n),  60'(nfb * BVS * BHL));

    // Mid-frame restart, located from the DUT's own position with a bounded search.
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(1'b1, 1'b0);
      found = (a_h == 14'd5) && (a_v == 14'd3);
    end
    check("ext_reach", 60'({a_h, a_v}), 60'({14'd5, 14'd3}));
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("ext_restart_a", 60'({a_h, a_v}), 60'(0));
    check("ext_restart_b", 60'({b_h, b_v}), 60'(0));
    for (int i = 0; i < 2 * AHL * AVL; i++) step(1'b1, 1'b0);

    // Held ext_sync pins both rasters at the origin.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    check("ext_held", 60'({a_h, a_v, b_h, b_v}), 60'(0));

    // Random resets (with priority over ext_sync) and restart pulses.
    for (int i = 0; i < 2000; i++) begin
      step(logic'($urandom_range(0, 149) != 0), logic'($urandom_range(0, 79) == 0));
    end

    // Reset in the middle of an active line.
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(1'b1, 1'b0);
      found = (a_den == 1'b1) && (a_x == 14'd3);
    end
    check("midline_reach", 60'({a_den, a_x}), 60'({1'b1, 14'd3}));
    step(1'b0, 1'b0);
    check("midline_reset_a", 60'({a_h, a_v, a_x, a_y, a_vs, a_hs, a_den, a_ls}), rst_vec(APOL));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
